// File: rtl/load_store_unit_if.sv
// Core/memory/writeback bundle for the load/store unit.
// The unit takes the slave view; whatever drives requests and memory takes the master view.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding RISC-V load/store unit: lane steering, alignment checks,
// load extension, one registered response per accepted request.
//
// state | meaning
// IDLE  | ready for a request; decode and latch on req_valid
// MREQ  | memory request presented, held until mem_ready
// MWAIT | load accepted by memory, waiting for mem_rvalid
// RESP  | one-cycle response pulse to writeback
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

    state_t      state;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        legal;
    logic        misaligned;
    logic [3:0]  wmask_n;
    logic [31:0] wdata_n;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    always_comb begin
        legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !bus.req_store;
            default:                legal = 1'b0;
        endcase

        misaligned = 1'b0;
        if (bus.req_funct3[1:0] == 2'b01)
            misaligned = bus.req_addr[0];
        else if (bus.req_funct3[1:0] == 2'b10)
            misaligned = |bus.req_addr[1:0];

        // Stores replicate the datum across lanes; the mask picks the live bytes.
        wmask_n = 4'b0000;
        wdata_n = 32'h0;
        if (bus.req_store) begin
            case (bus.req_funct3[1:0])
                2'b00: begin
                    wmask_n = 4'b0001 << bus.req_addr[1:0];
                    wdata_n = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    wmask_n = 4'b0011 << bus.req_addr[1:0];
                    wdata_n = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    wmask_n = 4'b1111;
                    wdata_n = bus.req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        load_byte = 8'h0;
        case (off_q)
            2'd0: load_byte = bus.mem_rdata[7:0];
            2'd1: load_byte = bus.mem_rdata[15:8];
            2'd2: load_byte = bus.mem_rdata[23:16];
            default: load_byte = bus.mem_rdata[31:24];
        endcase
        load_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        load_ext = bus.mem_rdata;
        case (funct3_q)
            3'b000: load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100: load_ext = {24'h0, load_byte};
            3'b001: load_ext = {{16{load_half[15]}}, load_half};
            3'b101: load_ext = {16'h0, load_half};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            store_q       <= 1'b0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            bus.req_ready <= 1'b1;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wmask <= 4'b0000;
            bus.mem_wdata <= 32'h0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        store_q       <= bus.req_store;
                        funct3_q      <= bus.req_funct3;
                        off_q         <= bus.req_addr[1:0];
                        bus.req_ready <= 1'b0;
                        if (legal && !misaligned) begin
                            bus.mem_valid <= 1'b1;
                            bus.mem_we    <= bus.req_store;
                            bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            bus.mem_wmask <= wmask_n;
                            bus.mem_wdata <= wdata_n;
                            state         <= MREQ;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= 32'h0;
                            state         <= RESP;
                        end
                    end
                end
                MREQ: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_wmask <= 4'b0000;
                        bus.mem_wdata <= 32'h0;
                        if (store_q) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_rdata <= 32'h0;
                            state         <= RESP;
                        end else begin
                            state <= MWAIT;
                        end
                    end
                end
                MWAIT: begin
                    if (bus.mem_rvalid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= load_ext;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= 32'h0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected memory requests
// and responses, negedge monitors compare whatever the unit presents.
module tb_load_store_unit;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wd;
    } mem_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    mem_t mq[$];
    rsp_t rq[$];

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_valid) begin
                chk("req_ready_low_in_mreq", 32'(bus.req_ready), 32'd0);
                if (mq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_unexpected: got mem_valid=1 expected no access (cycle %0d)", cyc);
                end else begin
                    chk("mem_we",    32'(bus.mem_we),    32'(mq[0].we));
                    chk("mem_addr",  bus.mem_addr,       mq[0].addr);
                    chk("mem_wmask", 32'(bus.mem_wmask), 32'(mq[0].mask));
                    chk("mem_wdata", bus.mem_wdata,      mq[0].wd);
                    if (bus.mem_ready) void'(mq.pop_front());
                end
            end
            if (bus.rsp_valid) begin
                chk("req_ready_low_in_resp", 32'(bus.req_ready), 32'd0);
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    rsp_t e;
                    e = rq.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata,    e.rd);
                    chk("rsp_err",   32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_cycle", 32'(cyc),         32'(e.cyc));
                end
            end
        end
    end

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] mrd,
                         input int stall, input int rdel, input logic err,
                         input logic [31:0] exp_rd, input logic [3:0] exp_mask,
                         input logic [31:0] exp_wd);
        int c0;
        c0 = cyc;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        if (err)
            rq.push_back('{32'h0, 1'b1, c0 + 1});
        else begin
            mq.push_back('{st, {addr[31:2], 2'b00}, exp_mask, exp_wd});
            rq.push_back('{exp_rd, 1'b0, st ? c0 + 2 + stall : c0 + 2 + stall + rdel});
        end
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h0;
        if (err) begin
            @(posedge clk); #1;
            return;
        end
        repeat (stall) begin @(posedge clk); #1; end
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        if (!st) begin
            repeat (rdel - 1) begin @(posedge clk); #1; end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mrd;
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'hA5A5_A5A5;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hA5A5_A5A5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        chk("rst_mem_addr",  bus.mem_addr,       32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // stores: st f3 addr wdata mrd stall rdel err exp_rd mask wdata
        issue(1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 4'b1111, 32'hDEAD_BEEF);
        issue(1, 3'b000, 32'h103, 32'h0000_00AB, 0, 0, 1, 0, 0, 4'b1000, 32'hABAB_ABAB);
        issue(1, 3'b001, 32'h102, 32'h5566_1234, 0, 0, 1, 0, 0, 4'b1100, 32'h1234_1234);
        issue(1, 3'b000, 32'h101, 32'h7777_77CD, 0, 2, 1, 0, 0, 4'b0010, 32'hCDCD_CDCD);
        // loads
        issue(0, 3'b000, 32'h102, 0, 32'h1280_3456, 0, 1, 0, 32'hFFFF_FF80, 0, 0);
        issue(0, 3'b100, 32'h102, 0, 32'h1280_3456, 0, 1, 0, 32'h0000_0080, 0, 0);
        issue(0, 3'b001, 32'h102, 0, 32'h1280_3456, 0, 1, 0, 32'h0000_1280, 0, 0);
        issue(0, 3'b010, 32'h100, 0, 32'h1280_3456, 0, 1, 0, 32'h1280_3456, 0, 0);
        issue(0, 3'b001, 32'h100, 0, 32'h1280_3456, 0, 2, 0, 32'h0000_3456, 0, 0);
        issue(0, 3'b001, 32'h102, 0, 32'h8001_0000, 0, 1, 0, 32'hFFFF_8001, 0, 0);
        issue(0, 3'b101, 32'h102, 0, 32'h8001_0000, 0, 1, 0, 32'h0000_8001, 0, 0);
        issue(0, 3'b000, 32'h100, 0, 32'h1280_3456, 0, 1, 0, 32'h0000_0056, 0, 0);
        issue(0, 3'b100, 32'h101, 0, 32'h1280_9456, 0, 1, 0, 32'h0000_0094, 0, 0);
        // errors: misaligned and illegal funct3
        issue(0, 3'b001, 32'h101, 0, 0, 0, 1, 1, 0, 0, 0);
        issue(0, 3'b010, 32'h102, 0, 0, 0, 1, 1, 0, 0, 0);
        issue(0, 3'b011, 32'h100, 0, 0, 0, 1, 1, 0, 0, 0);
        issue(1, 3'b100, 32'h100, 32'h1, 0, 0, 1, 1, 0, 0, 0);
        issue(1, 3'b001, 32'h103, 32'h1, 0, 0, 1, 1, 0, 0, 0);
        issue(1, 3'b010, 32'h101, 32'h1, 0, 0, 1, 1, 0, 0, 0);
        // stalled load: mem_ready low 3 cycles, rvalid 4 cycles after acceptance
        issue(0, 3'b010, 32'h104, 0, 32'hCAFE_F00D, 3, 4, 0, 32'hCAFE_F00D, 0, 0);

        // reset while waiting for load data
        mq.push_back('{1'b0, 32'h200, 4'b0000, 32'h0});
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h200;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hA5A5_A5A5;
        repeat (3) @(posedge clk);
        #1;
        issue(1, 3'b010, 32'h208, 32'h0BAD_F00D, 0, 0, 1, 0, 0, 4'b1111, 32'h0BAD_F00D);

        repeat (3) @(posedge clk);
        #1;
        chk("mem_queue_drained", 32'(mq.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
